// File: rtl/program_memory.sv
// program_memory
// Run-time loadable instruction memory for the lab CPU. The CPU fetches
// combinationally through iAddress/oInstruction. A host writes a new program
// through a valid/ready load port. A control FSM clears the array after reset
// and before every load, and holds the CPU while the contents change.
//
// Ports
//   Clock          in   single clock, rising edge
//   Reset          in   synchronous, active-low
//   iAddress       in   CPU fetch address (ADDR_WIDTH)
//   oInstruction   out  fetched word (combinational)
//   iLoadStart     in   request a new load (honoured only in IDLE)
//   iLoadValid     in   iLoadData is valid
//   iLoadData      in   program word
//   iLoadLast      in   final word of the program
//   oLoadReady     out  a word is accepted this cycle
//   oCpuHold       out  CPU must stall with PC at 0
//   oLoadDone      out  one-cycle pulse when a load completes
//   oLoadCount     out  words accepted in the current or last load
//   oLoadOverflow  out  sticky: host offered more than DEPTH words
//
// state    | meaning
// ---------+-------------------------------------------------------------
// CLEAR    | ptr walks 0..DEPTH-1 writing FILL_WORD; then LOAD or IDLE
// LOAD     | accepting words; extra words beyond DEPTH are dropped
// DONE     | single cycle, oLoadDone high
// IDLE     | CPU runs from memory; waits for iLoadStart

module program_memory #(
   parameter int                    DATA_WIDTH = 28,
   parameter int                    ADDR_WIDTH = 16,
   parameter int                    DEPTH      = 256,
   parameter logic [DATA_WIDTH-1:0] FILL_WORD  = '0,
   parameter logic [DATA_WIDTH-1:0] OOR_WORD   = '0,
   parameter int                    CNT_W      = $clog2(DEPTH) + 1
) (
   input  logic                  Clock,
   input  logic                  Reset,
   input  logic [ADDR_WIDTH-1:0] iAddress,
   output logic [DATA_WIDTH-1:0] oInstruction,
   input  logic                  iLoadStart,
   input  logic                  iLoadValid,
   input  logic [DATA_WIDTH-1:0] iLoadData,
   input  logic                  iLoadLast,
   output logic                  oLoadReady,
   output logic                  oCpuHold,
   output logic                  oLoadDone,
   output logic [CNT_W-1:0]      oLoadCount,
   output logic                  oLoadOverflow
);

   localparam int                IDX_W    = $clog2(DEPTH);
   localparam logic [CNT_W-1:0]  DEPTH_C  = CNT_W'(DEPTH);
   localparam logic [CNT_W-1:0]  LAST_IDX = CNT_W'(DEPTH - 1);
   // One extra bit so DEPTH = 2^ADDR_WIDTH is representable.
   localparam logic [ADDR_WIDTH:0] DEPTH_A = (ADDR_WIDTH + 1)'(DEPTH);

   typedef enum logic [1:0] {
      ST_CLEAR,
      ST_LOAD,
      ST_DONE,
      ST_IDLE
   } state_t;

   state_t                  state;
   logic [CNT_W-1:0]        ptr;
   logic                    load_pending;
   logic [CNT_W-1:0]        load_count;
   logic                    overflow;

   logic [DATA_WIDTH-1:0]   mem [DEPTH];
   logic                    mem_we;
   logic [DATA_WIDTH-1:0]   mem_wd;

   always_ff @(posedge Clock) begin
      if (!Reset) begin
         state        <= ST_CLEAR;
         ptr          <= '0;
         load_pending <= 1'b0;
         load_count   <= '0;
         overflow     <= 1'b0;
      end else begin
         case (state)
            ST_CLEAR: begin
               if (ptr == LAST_IDX) begin
                  ptr          <= '0;
                  load_pending <= 1'b0;
                  state        <= load_pending ? ST_LOAD : ST_IDLE;
               end else begin
                  ptr <= ptr + 1'b1;
               end
            end
            ST_LOAD: begin
               if (iLoadValid) begin
                  if (ptr < DEPTH_C) begin
                     ptr        <= ptr + 1'b1;
                     load_count <= load_count + 1'b1;
                  end else begin
                     // Array full: word is dropped, count stays at DEPTH.
                     overflow <= 1'b1;
                  end
                  if (iLoadLast) begin
                     state <= ST_DONE;
                  end
               end
            end
            ST_DONE: begin
               state <= ST_IDLE;
            end
            ST_IDLE: begin
               if (iLoadStart) begin
                  state        <= ST_CLEAR;
                  ptr          <= '0;
                  load_pending <= 1'b1;
                  load_count   <= '0;
                  overflow     <= 1'b0;
               end
            end
            default: begin
               state <= ST_CLEAR;
               ptr   <= '0;
            end
         endcase
      end
   end

   // Single write port, owned by the FSM. Suppressed while Reset is low so an
   // aborted load leaves no stray write on the abort edge.
   always_comb begin
      mem_we = 1'b0;
      mem_wd = FILL_WORD;
      if (Reset) begin
         if (state == ST_CLEAR) begin
            mem_we = 1'b1;
         end else if (state == ST_LOAD && iLoadValid && ptr < DEPTH_C) begin
            mem_we = 1'b1;
            mem_wd = iLoadData;
         end
      end
   end

   always_ff @(posedge Clock) begin
      if (mem_we) begin
         mem[ptr[IDX_W-1:0]] <= mem_wd;
      end
   end

   assign oLoadReady    = (state == ST_LOAD);
   assign oCpuHold      = (state != ST_IDLE);
   assign oLoadDone     = (state == ST_DONE);
   assign oLoadCount    = load_count;
   assign oLoadOverflow = overflow;

   always_comb begin
      if (oCpuHold) begin
         oInstruction = FILL_WORD;
      end else if ({1'b0, iAddress} >= DEPTH_A) begin
         oInstruction = OOR_WORD;
      end else begin
         oInstruction = mem[iAddress[IDX_W-1:0]];
      end
   end

endmodule

// File: tb/tb_program_memory.sv
// Directed bench for program_memory with DEPTH=16. Non-zero fill and
// out-of-range words make cleared and out-of-range reads distinguishable.

module tb_program_memory;

   localparam int              DW    = 28;
   localparam int              AW    = 16;
   localparam int              DEPTH = 16;
   localparam int              CW    = 5;
   localparam logic [DW-1:0]   FILL  = 28'hABCDEF0;
   localparam logic [DW-1:0]   OOR   = 28'h5A5A5A5;

   logic            clk_sys;
   logic            rst_b;
   logic [AW-1:0]   address;
   logic [DW-1:0]   instruction;
   logic            load_start;
   logic            load_valid;
   logic [DW-1:0]   load_data;
   logic            load_last;
   logic            load_ready;
   logic            cpu_hold;
   logic            load_done;
   logic [CW-1:0]   load_count;
   logic            load_overflow;

   int              checks;
   int              errors;
   int              done_pulses;
   logic [DW-1:0]   exp_mem [DEPTH];

   program_memory #(
      .DATA_WIDTH (DW),
      .ADDR_WIDTH (AW),
      .DEPTH      (DEPTH),
      .FILL_WORD  (FILL),
      .OOR_WORD   (OOR)
   ) dut (
      .Clock         (clk_sys),
      .Reset         (rst_b),
      .iAddress      (address),
      .oInstruction  (instruction),
      .iLoadStart    (load_start),
      .iLoadValid    (load_valid),
      .iLoadData     (load_data),
      .iLoadLast     (load_last),
      .oLoadReady    (load_ready),
      .oCpuHold      (cpu_hold),
      .oLoadDone     (load_done),
      .oLoadCount    (load_count),
      .oLoadOverflow (load_overflow)
   );

   initial clk_sys = 1'b0;
   always #5 clk_sys = ~clk_sys;

   always @(negedge clk_sys) begin
      if (load_done) done_pulses++;
   end

   task automatic check(input string tag, input logic [31:0] observed,
                        input logic [31:0] expected);
      checks++;
      if (observed !== expected) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", tag, observed, expected);
      end
   endtask

   task automatic tick();
      @(posedge clk_sys);
      #1;
   endtask

   task automatic wait_hold_low(input string tag, input int expected_cycles);
      int n;
      n = 0;
      while (cpu_hold && n < 100) begin
         tick();
         n++;
      end
      check(tag, n, expected_cycles);
   endtask

   task automatic check_reads(input string tag);
      for (int a = 0; a < DEPTH; a++) begin
         address = AW'(a);
         #1;
         check($sformatf("%s_rd%0d", tag, a), instruction, exp_mem[a]);
      end
      address = 16'd16;
      #1;
      check({tag, "_oor16"}, instruction, OOR);
      address = 16'hFFFF;
      #1;
      check({tag, "_oorffff"}, instruction, OOR);
      address = '0;
   endtask

   // Full load: start, wait for ready, stream n words (optionally with random
   // valid gaps), then verify done pulse, counters and memory image.
   task automatic load_program(input string tag, input int n,
                               input logic [DW-1:0] base, input bit gaps);
      int   i;
      int   cyc;
      int   w;
      bit   v;
      bit   rdy;
      load_start = 1'b1;
      tick();
      load_start = 1'b0;
      check({tag, "_cnt_clr"}, load_count, 0);
      check({tag, "_ovf_clr"}, load_overflow, 0);
      // Valid asserted during CLEAR must be ignored.
      load_valid = 1'b1;
      load_data  = 28'hBAD0BAD;
      w = 0;
      while (!load_ready && w < 100) begin
         tick();
         w++;
      end
      check({tag, "_latency"}, w, DEPTH);
      for (int k = 0; k < DEPTH; k++) exp_mem[k] = FILL;
      done_pulses = 0;
      i   = 0;
      cyc = 0;
      while (i < n && cyc < 500) begin
         v = gaps ? 1'($urandom_range(0, 1)) : 1'b1;
         load_valid = v;
         load_data  = base + DW'(i);
         load_last  = (i == n - 1);
         rdy = load_ready;
         tick();
         cyc++;
         if (v && rdy) begin
            if (i < DEPTH) exp_mem[i] = base + DW'(i);
            i++;
         end
      end
      load_valid = 1'b0;
      load_last  = 1'b0;
      check({tag, "_words_sent"}, i, n);
      check({tag, "_done_hi"}, load_done, 1);
      check({tag, "_ready_lo"}, load_ready, 0);
      tick();
      check({tag, "_done_lo"}, load_done, 0);
      check({tag, "_hold_lo"}, cpu_hold, 0);
      check({tag, "_done_pulses"}, done_pulses, 1);
      check({tag, "_count"}, load_count, (n > DEPTH) ? DEPTH : n);
      check({tag, "_ovf"}, load_overflow, (n > DEPTH) ? 1 : 0);
      check_reads(tag);
   endtask

   initial begin
      checks      = 0;
      errors      = 0;
      done_pulses = 0;
      rst_b       = 1'b0;
      address     = '0;
      load_start  = 1'b0;
      load_valid  = 1'b0;
      load_data   = '0;
      load_last   = 1'b0;
      for (int k = 0; k < DEPTH; k++) exp_mem[k] = FILL;

      // 1. Reset and post-reset clear
      repeat (3) tick();
      check("rst_hold", cpu_hold, 1);
      check("rst_ready", load_ready, 0);
      check("rst_done", load_done, 0);
      check("rst_count", load_count, 0);
      check("rst_ovf", load_overflow, 0);
      check("rst_instr", instruction, FILL);
      rst_b = 1'b1;
      wait_hold_low("rst_clear_cycles", DEPTH);
      check_reads("rst");

      // 2. Basic load
      load_program("basic", 5, 28'h1000001, 1'b0);

      // 3. Valid gaps
      load_program("gaps", 8, 28'h2000010, 1'b1);

      // 4. Overflow
      load_program("ovf", 18, 28'h3000100, 1'b0);

      // 5. Reload clears the previous program (overflow cleared by start)
      load_program("reload_a", 10, 28'h4000000, 1'b0);
      load_program("reload_b", 3, 28'h5000000, 1'b0);

      // 6. Ignored start during LOAD, then abort by reset
      load_start = 1'b1;
      tick();
      load_start = 1'b0;
      begin
         int w;
         w = 0;
         while (!load_ready && w < 100) begin
            tick();
            w++;
         end
         check("abort_latency", w, DEPTH);
      end
      done_pulses = 0;
      for (int i = 0; i < 4; i++) begin
         load_valid = 1'b1;
         load_data  = 28'h6000000 + DW'(i);
         tick();
      end
      load_valid = 1'b0;
      check("abort_count4", load_count, 4);
      load_start = 1'b1;
      tick();
      load_start = 1'b0;
      check("abort_start_ignored", load_ready, 1);
      check("abort_count_kept", load_count, 4);
      rst_b = 1'b0;
      tick();
      check("abort_hold", cpu_hold, 1);
      check("abort_ready", load_ready, 0);
      check("abort_count_rst", load_count, 0);
      rst_b = 1'b1;
      wait_hold_low("abort_clear_cycles", DEPTH);
      check("abort_idle_ready", load_ready, 0);
      for (int k = 0; k < DEPTH; k++) exp_mem[k] = FILL;
      check_reads("abort");
      check("abort_no_done", done_pulses, 0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/program_memory.md
# program_memory

Parametrised, run-time loadable instruction memory for the lab CPU, replacing the hard-coded instruction ROM. The CPU reads instructions combinationally through the same `iAddress`/`oInstruction` pair. A load port with a valid/ready handshake lets a host (testbench, UART bridge, or switch panel) write a new program without resynthesis. A control FSM clears memory after reset and on every load, and holds the CPU while contents change.

## Interface
- `DATA_WIDTH`, 28: instruction word width.
- `ADDR_WIDTH`, 16: CPU address width.
- `DEPTH`, 256: number of words; must satisfy 2 ≤ DEPTH ≤ 2^ADDR_WIDTH.
- `FILL_WORD`, 28'd0: value written to every location during a clear.
- `OOR_WORD`, 28'd0: value returned when `iAddress` ≥ DEPTH.
- `CNT_W`, $clog2(DEPTH)+1: width of the word counter (derived).
- `Clock` in 1: single clock; all state updates on the rising edge.
- `Reset` in 1: synchronous, active-low.
- `iAddress` in ADDR_WIDTH: CPU fetch address.
- `oInstruction` out DATA_WIDTH: fetched instruction (combinational).
- `iLoadStart` in 1: request a new load; sampled only in IDLE.
- `iLoadValid` in 1: `iLoadData` is valid.
- `iLoadData` in DATA_WIDTH: program word to write.
- `iLoadLast` in 1: qualifies the final word of a program.
- `oLoadReady` out 1: memory accepts a word this cycle.
- `oCpuHold` out 1: CPU must stall and keep its PC at 0.
- `oLoadDone` out 1: one-cycle pulse when a load completes.
- `oLoadCount` out CNT_W: words accepted in the current or last load.
- `oLoadOverflow` out 1: sticky flag, set when the host offers more than DEPTH words.

## Operation
- Storage is a register array of DEPTH × DATA_WIDTH. There is one write port, driven only by the FSM.
- FSM states:
  - CLEAR: `ptr` walks 0..DEPTH-1, writing `FILL_WORD` at `ptr`, one word per cycle. After writing DEPTH-1 the FSM goes to LOAD if the clear was started by `iLoadStart`, otherwise to IDLE.
  - LOAD: `oLoadReady`=1. A transfer occurs when `iLoadValid`&&`oLoadReady`.
    - While `ptr` < DEPTH, each transfer writes `iLoadData` to `mem[ptr]`, increments `ptr`, and increments `oLoadCount`.
    - Once `ptr` = DEPTH, the transfer's data is discarded, `oLoadOverflow` is set, and `oLoadCount` saturates at DEPTH.
    - A transfer with `iLoadLast`=1 moves the FSM to DONE, whether or not the word was written.
  - DONE: one cycle with `oLoadDone`=1, then IDLE.
  - IDLE: when `iLoadStart`=1, the FSM goes to CLEAR with `ptr`=0 and a load pending. At the same edge, `oLoadCount` and `oLoadOverflow` are cleared.
- `oCpuHold` = 1 in CLEAR, LOAD and DONE; 0 only in IDLE.
- Read path:
  - If `oCpuHold`=1, `oInstruction` = `FILL_WORD`.
  - Otherwise, if `iAddress` ≥ DEPTH, `oInstruction` = `OOR_WORD`.
  - Otherwise `oInstruction` = `mem[iAddress]`.
  - The comparison is performed at full ADDR_WIDTH.
- `iLoadStart` is ignored in CLEAR, LOAD and DONE.
- `iLoadValid` is ignored outside LOAD, and no data is consumed.
- `iLoadLast` without `iLoadValid` has no effect.

## Timing
- While `Reset`=0 at a rising edge:
  - state is CLEAR with no load pending, `ptr`=0;
  - `oLoadCount`=0, `oLoadOverflow`=0, `oLoadDone`=0;
  - `oLoadReady`=0, `oCpuHold`=1, `oInstruction`=`FILL_WORD`.
- Post-reset clear: first write at the first edge with `Reset`=1. IDLE is reached DEPTH edges after reset release.
- Load latency: `iLoadStart` sampled at edge N gives CLEAR from N to N+DEPTH and LOAD with `oLoadReady`=1 after edge N+DEPTH.
- Throughput: one word per cycle when `iLoadValid` is held high.
- The last transfer at edge M gives DONE (`oLoadDone`=1) in cycle M..M+1. IDLE is reached after M+1; `oCpuHold` falls then, and new contents are readable in the same cycle.
- Reset asserted mid-CLEAR or mid-LOAD aborts the operation at that edge. All partially loaded contents are discarded and the post-reset clear restarts.
- All outputs other than `oInstruction` are registered or pure state decodes. No combinational path exists from `iLoadValid` to `oLoadReady`.

## Test plan
Benches run with DEPTH=16 and DATA_WIDTH=28 unless stated.

1. **Reset/clear:** hold `Reset`=0 for 3 cycles, then release. `oCpuHold`=1 for exactly 16 cycles, then 0. Every address 0..15 reads `FILL_WORD`. Address 16 and 16'hFFFF read `OOR_WORD`.
2. **Basic load:** pulse `iLoadStart`, then stream words 28'h1000001..28'h1000005 with `iLoadLast` on the 5th. `oLoadCount`=5 and `oLoadDone` pulses once. Reads give `mem[0..4]` = streamed values and `mem[5..15]` = `FILL_WORD`.
3. **Backpressure/gaps:** toggle `iLoadValid` randomly (about 50%) over 8 words. Only cycles with valid && ready write, in order, with no duplicates or skips. `oLoadCount`=8.
4. **Overflow:** stream 18 words with last on the 18th. Words 0..15 are stored, words 16..17 are dropped. `oLoadOverflow`=1, `oLoadCount`=16, and `oLoadDone` pulses.
5. **Reload clears old program:** load 10 words, then load 3 words. Addresses 3..9 read `FILL_WORD`, and `oLoadOverflow` is cleared by the new start.
6. **Abort and ignores:**
   - `iLoadStart` during LOAD has no effect.
   - `Reset`=0 after 4 of 8 words leads to a full 16-cycle clear.
   - All addresses read `FILL_WORD` afterwards, and `oLoadDone` never pulses.
